// File: rtl/ch4_reg_ctrl.sv
// ch4_reg_ctrl: CPU register file (NR41-NR44) and control stage for noise
// channel 4. It holds the envelope and polynomial registers and runs the
// length counter. It sequences the delayed trigger into a one-clock restart
// pulse and tracks the channel-active flag that NR52 reports.
module ch4_reg_ctrl #(
  parameter int LEN_BITS   = 6,  // length counter width (at most 8)
  parameter int TRIG_DELAY = 2   // clocks from trigger write to restart pulse, >= 1
) (
  input  logic       dova_phi,
  input  logic       apu_reset,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic       ff20,
  input  logic       ff21,
  input  logic       ff22,
  input  logic       ff23,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  input  logic       len_tick,
  output logic [7:0] ff21_q,
  output logic [7:0] ff22_q,
  output logic       ff23_d6,
  output logic       ff23_d7,
  output logic       ch4_restart,
  output logic       ch4_active,
  output logic       nch4_amp_en
);

  localparam int DLY_W = $clog2(TRIG_DELAY + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2
  } trig_state_e;

  trig_state_e         state_q, state_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [LEN_BITS-1:0] len_cnt_q, len_cnt_d;
  logic [7:0]          ff21_d, ff22_d;
  logic                ff23_d6_q, ff23_d6_d;
  logic                ff23_d7_q, ff23_d7_d;
  logic                ch4_restart_q, ch4_restart_d;
  logic                ch4_active_q, ch4_active_d;

  logic wr_ff20, wr_ff21, wr_ff22, wr_ff23;
  logic trig_wr;
  logic fire_go;
  logic len_step;
  logic dac_off_next;

  // Qualified write strobes for each register.
  assign wr_ff20 = cpu_wr & ff20;
  assign wr_ff21 = cpu_wr & ff21;
  assign wr_ff22 = cpu_wr & ff22;
  assign wr_ff23 = cpu_wr & ff23;
  assign trig_wr = wr_ff23 & cpu_wdata[7];

  // The DAC is off when the envelope initial volume and direction bits are all zero.
  assign nch4_amp_en  = ~|ff21_q[7:3];
  assign dac_off_next = ~|ff21_d[7:3];

  // Combinational read mux; unselected or idle bus floats high.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    cpu_rdata = 8'hFF;
    if (cpu_rd) begin
      if (ff21)      cpu_rdata = ff21_q;
      else if (ff22) cpu_rdata = ff22_q;
      else if (ff23) cpu_rdata = {1'b1, ff23_d6_q, 6'h3F};
    end
  end

  // Plain register updates from CPU writes.
  always_comb begin
    ff21_d    = wr_ff21 ? cpu_wdata : ff21_q;
    ff22_d    = wr_ff22 ? cpu_wdata : ff22_q;
    ff23_d6_d = wr_ff23 ? cpu_wdata[6] : ff23_d6_q;
  end

  // Trigger sequencer: a trigger write always (re)starts the delay, so a
  // write landing on the expiring WAIT clock postpones the pulse instead of
  // doubling it, and a write during FIRE queues a second pulse.
  always_comb begin
    state_d       = state_q;
    dly_d         = dly_q;
    ff23_d7_d     = ff23_d7_q;
    ch4_restart_d = 1'b0;
    fire_go       = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_WAIT: begin
        if (dly_q == DLY_W'(1)) begin
          state_d = ST_FIRE;
          fire_go = 1'b1;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      ST_FIRE: begin
        state_d = ST_IDLE;
        dly_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (trig_wr) begin
      state_d   = ST_WAIT;
      dly_d     = DLY_W'(TRIG_DELAY);
      ff23_d7_d = 1'b1;
      fire_go   = 1'b0;
    end else if (fire_go) begin
      ch4_restart_d = 1'b1;
      ff23_d7_d     = 1'b0;
    end
  end

  // Length counter and channel-active flag. Precedence, lowest to highest:
  // hold, length expiry, trigger firing, DAC gating.
  always_comb begin
    len_cnt_d    = len_cnt_q;
    ch4_active_d = ch4_active_q;
    len_step     = len_tick & ff23_d6_q & ch4_active_q;
    if (wr_ff20) begin
      len_cnt_d = cpu_wdata[LEN_BITS-1:0];
    end else if (len_step) begin
      len_cnt_d = len_cnt_q + 1'b1;
      if (&len_cnt_q) ch4_active_d = 1'b0;
    end
    // An expired counter already sits at zero, which is the reload value
    // for a full-length run, so firing leaves len_cnt untouched.
    if (fire_go && !nch4_amp_en) ch4_active_d = 1'b1;
    if (dac_off_next)            ch4_active_d = 1'b0;
  end

  // All state flops; an asynchronous reset also aborts a pending trigger.
  always_ff @(posedge dova_phi or posedge apu_reset) begin
    if (apu_reset) begin
      state_q       <= ST_IDLE;
      dly_q         <= '0;
      len_cnt_q     <= '0;
      ff21_q        <= 8'h00;
      ff22_q        <= 8'h00;
      ff23_d6_q     <= 1'b0;
      ff23_d7_q     <= 1'b0;
      ch4_restart_q <= 1'b0;
      ch4_active_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      dly_q         <= dly_d;
      len_cnt_q     <= len_cnt_d;
      ff21_q        <= ff21_d;
      ff22_q        <= ff22_d;
      ff23_d6_q     <= ff23_d6_d;
      ff23_d7_q     <= ff23_d7_d;
      ch4_restart_q <= ch4_restart_d;
      ch4_active_q  <= ch4_active_d;
    end
  end

  assign ff23_d6     = ff23_d6_q;
  assign ff23_d7     = ff23_d7_q;
  assign ch4_restart = ch4_restart_q;
  assign ch4_active  = ch4_active_q;

endmodule

// File: tb/tb_ch4_reg_ctrl.sv
// tb_ch4_reg_ctrl: directed-vector bench for the channel-4 register/control stage.
module tb_ch4_reg_ctrl;

  logic       dova_phi = 1'b0;
  logic       apu_reset;
  logic       cpu_wr, cpu_rd;
  logic       ff20, ff21, ff22, ff23;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       len_tick;
  logic [7:0] ff21_q, ff22_q;
  logic       ff23_d6, ff23_d7, ch4_restart, ch4_active, nch4_amp_en;

  int n_checks = 0;
  int n_pass   = 0;

  ch4_reg_ctrl #(.LEN_BITS(6), .TRIG_DELAY(2)) dut (
    .dova_phi    (dova_phi),
    .apu_reset   (apu_reset),
    .cpu_wr      (cpu_wr),
    .cpu_rd      (cpu_rd),
    .ff20        (ff20),
    .ff21        (ff21),
    .ff22        (ff22),
    .ff23        (ff23),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .len_tick    (len_tick),
    .ff21_q      (ff21_q),
    .ff22_q      (ff22_q),
    .ff23_d6     (ff23_d6),
    .ff23_d7     (ff23_d7),
    .ch4_restart (ch4_restart),
    .ch4_active  (ch4_active),
    .nch4_amp_en (nch4_amp_en)
  );

  always #5 dova_phi = ~dova_phi;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%02h, expected 'h%02h", tag, got, exp);
  endtask

  task automatic sel(input int a);
    ff20 = (a == 'h20);
    ff21 = (a == 'h21);
    ff22 = (a == 'h22);
    ff23 = (a == 'h23);
  endtask

  // One-clock write; returns on the falling edge after the sampling edge.
  task automatic wr(input int a, input logic [7:0] d);
    @(negedge dova_phi);
    sel(a);
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    @(negedge dova_phi);
    cpu_wr = 1'b0;
    sel(0);
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    sel(a);
    cpu_rd = 1'b1;
    #1;
    d = cpu_rdata;
    cpu_rd = 1'b0;
    sel(0);
  endtask

  task automatic tick();
    @(negedge dova_phi);
    len_tick = 1'b1;
    @(negedge dova_phi);
    len_tick = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    logic [7:0] r;
    check({pfx, "_ff21"},    ff21_q, 8'h00);
    check({pfx, "_ff22"},    ff22_q, 8'h00);
    check({pfx, "_d6"},      ff23_d6, 1'b0);
    check({pfx, "_d7"},      ff23_d7, 1'b0);
    check({pfx, "_restart"}, ch4_restart, 1'b0);
    check({pfx, "_active"},  ch4_active, 1'b0);
    check({pfx, "_amp_en"},  nch4_amp_en, 1'b1);
    rd('h20, r);
    check({pfx, "_rd20"}, r, 8'hFF);
    rd('h23, r);
    check({pfx, "_rd23"}, r, 8'hBF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r;
    int drops, pulses, pos;

    apu_reset = 1'b1;
    cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_wdata = 8'h00; len_tick = 1'b0;
    sel(0);
    repeat (3) @(negedge dova_phi);
    check_reset_state("por");
    apu_reset = 1'b0;

    // Register writes and read-back; idle bus reads 'hFF.
    wr('h22, 8'h5A);
    check("ff22_q", ff22_q, 8'h5A);
    rd('h22, r);
    check("rd22", r, 8'h5A);
    wr('h21, 8'hF0);
    rd('h21, r);
    check("rd21", r, 8'hF0);
    check("amp_en_on", nch4_amp_en, 1'b0);
    sel('h21);
    #1;
    check("rd_idle", cpu_rdata, 8'hFF);
    sel(0);

    // Trigger with TRIG_DELAY=2: pulse two clocks after the write edge.
    wr('h23, 8'h80);
    check("trg_e0_restart", ch4_restart, 1'b0);
    check("trg_e0_d7", ff23_d7, 1'b1);
    @(negedge dova_phi);
    check("trg_e1_restart", ch4_restart, 1'b0);
    @(negedge dova_phi);
    check("trg_e2_restart", ch4_restart, 1'b1);
    check("trg_e2_d7", ff23_d7, 1'b0);
    check("trg_e2_active", ch4_active, 1'b1);
    @(negedge dova_phi);
    check("trg_e3_restart", ch4_restart, 1'b0);
    rd('h23, r);
    check("rd23_d6lo", r, 8'hBF);

    // Length: 60 -> expiry on the 4th tick; retrigger runs a full 64 ticks.
    wr('h20, 8'h3C);
    wr('h23, 8'hC0);
    repeat (2) @(negedge dova_phi);
    check("len_fire_active", ch4_active, 1'b1);
    rd('h23, r);
    check("rd23_d6hi", r, 8'hFF);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("len_tick%0d", i), ch4_active, (i == 4) ? 1'b0 : 1'b1);
    end
    wr('h23, 8'hC0);
    repeat (2) @(negedge dova_phi);
    check("len64_start", ch4_active, 1'b1);
    drops = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (!ch4_active) drops++;
    end
    check("len64_hold", 8'(drops), 8'd0);
    tick();
    check("len64_expire", ch4_active, 1'b0);

    // DAC off: restart still pulses, channel stays off.
    wr('h21, 8'h07);
    check("dac_off_amp_en", nch4_amp_en, 1'b1);
    wr('h23, 8'h80);
    repeat (2) @(negedge dova_phi);
    check("dac_off_restart", ch4_restart, 1'b1);
    check("dac_off_active", ch4_active, 1'b0);
    wr('h21, 8'hF0);
    wr('h23, 8'h80);
    repeat (2) @(negedge dova_phi);
    check("dac_on_active", ch4_active, 1'b1);
    wr('h21, 8'h00);
    check("dac_kill_active", ch4_active, 1'b0);
    check("dac_kill_amp_en", nch4_amp_en, 1'b1);

    // Two trigger writes on consecutive clocks: one pulse, 2 clocks after the second.
    @(negedge dova_phi);
    sel('h23); cpu_wdata = 8'h80; cpu_wr = 1'b1;
    @(negedge dova_phi);
    @(negedge dova_phi);
    cpu_wr = 1'b0; sel(0);
    pulses = 0; pos = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge dova_phi);
      if (ch4_restart) begin pulses++; pos = i; end
    end
    check("dbl_pulses", 8'(pulses), 8'd1);
    check("dbl_pos", 8'(pos), 8'd1);

    // Trigger during FIRE: second pulse TRIG_DELAY clocks later.
    wr('h23, 8'h80);
    @(negedge dova_phi);
    @(negedge dova_phi);
    check("refire_first", ch4_restart, 1'b1);
    sel('h23); cpu_wdata = 8'h80; cpu_wr = 1'b1;
    @(negedge dova_phi);
    cpu_wr = 1'b0; sel(0);
    pulses = 0; pos = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge dova_phi);
      if (ch4_restart) begin pulses++; pos = i; end
    end
    check("refire_pulses", 8'(pulses), 8'd1);
    check("refire_pos", 8'(pos), 8'd1);

    // Ticks ignored while inactive; a trigger then one tick expires from 63.
    wr('h21, 8'hF0);
    wr('h20, 8'h3F);
    wr('h23, 8'h40);
    check("len63_d6", ff23_d6, 1'b1);
    check("len63_d7", ff23_d7, 1'b0);
    tick();
    check("len63_idle_tick", ch4_active, 1'b0);
    wr('h23, 8'hC0);
    repeat (2) @(negedge dova_phi);
    check("len63_fire", ch4_active, 1'b1);
    tick();
    check("len63_expire", ch4_active, 1'b0);

    // FF20 write beats a same-clock tick.
    wr('h23, 8'hC0);
    repeat (2) @(negedge dova_phi);
    @(negedge dova_phi);
    sel('h20); cpu_wdata = 8'h3F; cpu_wr = 1'b1; len_tick = 1'b1;
    @(negedge dova_phi);
    cpu_wr = 1'b0; len_tick = 1'b0; sel(0);
    check("wr_vs_tick_active", ch4_active, 1'b1);
    tick();
    check("wr_vs_tick_expire", ch4_active, 1'b0);

    // FIRE coincident with expiry: FIRE wins and the counter restarts at 0.
    wr('h23, 8'hC0);
    repeat (2) @(negedge dova_phi);
    wr('h20, 8'h3F);
    wr('h23, 8'hC0);
    @(negedge dova_phi);
    len_tick = 1'b1;
    @(negedge dova_phi);
    len_tick = 1'b0;
    check("fire_exp_restart", ch4_restart, 1'b1);
    check("fire_exp_active", ch4_active, 1'b1);
    tick();
    check("fire_exp_after", ch4_active, 1'b1);

    // Reset mid-WAIT aborts the pulse.
    wr('h23, 8'h80);
    apu_reset = 1'b1;
    #1;
    check_reset_state("rst");
    @(negedge dova_phi);
    apu_reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge dova_phi);
      if (ch4_restart) pulses++;
    end
    check("rst_no_pulse", 8'(pulses), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
